// File: rtl/mips_cpu_sequencer_if.sv
// Signal bundle between the multicycle sequencer and the memory, decoder and datapath.
// The master side drives the stimulus inputs and the slave side is the sequencer itself.
interface mips_cpu_sequencer_if #(parameter int STATE_W = 3);
    logic               waitrequest;
    logic               mem_access;
    logic [STATE_W-1:0] exec_len;
    logic               muldiv_busy;
    logic               muldiv_dep;
    logic               halt_req;
    logic [STATE_W-1:0] state;
    logic               exec_first;
    logic               exec_last;
    logic               active;
    logic               stall;
    logic [31:0]        instr_count;
    logic               timeout_err;

    modport master (
        output waitrequest, mem_access, exec_len, muldiv_busy, muldiv_dep, halt_req,
        input  state, exec_first, exec_last, active, stall, instr_count, timeout_err
    );

    modport slave (
        input  waitrequest, mem_access, exec_len, muldiv_busy, muldiv_dep, halt_req,
        output state, exec_first, exec_last, active, stall, instr_count, timeout_err
    );
endinterface

// File: rtl/mips_cpu_sequencer.sv
// Multicycle CPU state sequencer: FETCH -> DECODE -> EXEC1..EXECn with waitrequest and
// HI/LO hazard stalls, a bus-hang timeout into HALTED, and a retired-instruction counter.
module mips_cpu_sequencer #(
    parameter int STATE_W      = 3,
    parameter int MAX_EXEC     = 2,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_cpu_sequencer_if.slave   bus
);
    localparam int CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

    localparam logic [STATE_W-1:0] S_HALT   = '0;
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_EXEC1  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MAXE     = STATE_W'(MAX_EXEC);
    localparam logic [CW-1:0]      WT_LAST  = CW'(WAIT_TIMEOUT - 1);

    if (MAX_EXEC < 1 || MAX_EXEC + 3 > 2**STATE_W) begin : g_bad_params
        $error("mips_cpu_sequencer: MAX_EXEC must be >= 1 and MAX_EXEC+3 <= 2**STATE_W");
    end

    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] len_q, len_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               terr_q, terr_d;
    logic               wait_stall, md_stall, to_hit, retire;
    logic               is_exec, x_last;

    // States beyond EXEC(MAX_EXEC) are unreachable, so a lower bound is enough.
    assign is_exec = (state_q >= S_EXEC1);
    assign x_last  = is_exec && ((state_q - S_DECODE) == len_q);

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q <= S_FETCH;
            len_q   <= STATE_W'(1);
            wcnt_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin : next_state
        wait_stall = ((state_q == S_FETCH) || (is_exec && bus.mem_access)) && bus.waitrequest;
        md_stall   = (state_q == S_DECODE) && bus.muldiv_dep && bus.muldiv_busy;
        to_hit     = (WAIT_TIMEOUT != 0) && wait_stall && (wcnt_q >= WT_LAST);
        retire     = is_exec && !wait_stall && x_last;
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        // Any non-wait cycle, including a muldiv hold, breaks the consecutive run.
        wcnt_d     = '0;
        if (wait_stall)
            wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + CW'(1);

        if (state_q != S_HALT) begin
            if (to_hit) begin
                state_d = S_HALT;
                terr_d  = 1'b1;
            end else if (state_q == S_FETCH) begin
                if (!wait_stall) state_d = S_DECODE;
            end else if (state_q == S_DECODE) begin
                if (!md_stall) begin
                    state_d = S_EXEC1;
                    if (bus.exec_len == '0)       len_d = STATE_W'(1);
                    else if (bus.exec_len > MAXE) len_d = MAXE;
                    else                          len_d = bus.exec_len;
                end
            end else if (!wait_stall) begin
                if (retire) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = bus.halt_req ? S_HALT : S_FETCH;
                end else begin
                    state_d = state_q + STATE_W'(1);
                end
            end
        end
    end

    always_comb begin : outputs
        bus.stall      = wait_stall || md_stall;
        bus.active     = (state_q != S_HALT);
        bus.exec_first = (state_q == S_EXEC1);
        bus.exec_last  = x_last;
    end

    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
    assign bus.timeout_err = terr_q;
endmodule
